wb_arbiter_2m: RTL and testbench
================================

Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone B4 arbiter for the SoC bus.
- Masters are the core instruction fetch (m0) and load/store (m1). The slave side drives the shared interconnect: boot RAM, SDRAM window and peripherals.
- Grants ownership per bus cycle (CYC tenure) with round-robin fairness.
- A watchdog aborts stalled slave transfers with ERR so the core never hangs.

Parameters:
- TIMEOUT, 255: max consecutive owner-STB cycles without ACK/ERR/RTY before abort; 0 disables the watchdog.
- TW, $clog2(TIMEOUT+1) (min 1): watchdog counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- mN_cyc, mN_stb, mN_we  in  1 each  master N cycle/strobe/write (N=0,1).
- mN_adr  in  32  master N address.
- mN_dat_o  in  32  master N write data.
- mN_cti  in  3  master N cycle type.
- mN_dat_i  out  32  read data to master N.
- mN_ack, mN_err, mN_rty  out  1 each  terminations to master N.
- s_cyc, s_stb, s_we  out  1 each  to slave bus.
- s_adr  out  32.
- s_dat_o  out  32.
- s_cti  out  3.
- s_dat_i  in  32.
- s_ack, s_err, s_rty  in  1 each.
- gnt  out  2  one-hot current owner; 00 = none.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, gnt=00, last=1 (m0 wins the first tie), timer=0.
  - While gnt=00 or state != BUSY, all s_* outputs are 0.
  - All mN_ack/err/rty are 0 outside BUSY/ABORT as defined below.
  - rst mid-transfer drops s_cyc/s_stb the next cycle; no termination is forwarded.
- States: IDLE, BUSY, ABORT, DRAIN.
- IDLE:
  - Only m0_cyc=1: owner=0. Only m1_cyc=1: owner=1. Both: owner = ~last.
  - Next state is BUSY with gnt set. Arbitration latency is exactly 1 cycle from mN_cyc rising to s_cyc.
  - No cyc: stay in IDLE.
- BUSY:
  - Owner's cyc/stb/we/adr/dat_o/cti are combinationally muxed to s_*.
  - s_ack/s_err/s_rty are routed to the owner only. The non-owner's terminations are held at 0.
  - mN_dat_i = s_dat_i for both masters (broadcast); the qualifier is ack.
  - Owner cyc=0: next state is IDLE, last=owner, gnt=00. This costs one dead cycle between tenures, even when the other master is waiting.
  - Grant is held for the full CYC tenure, including CTI 010 bursts and idle STB=0 gaps. Non-owner requests never preempt.
- Watchdog (BUSY only):
  - timer increments on cycles with owner stb=1 and no s_ack/s_err/s_rty.
  - timer clears on any termination or on stb=0.
  - If TIMEOUT != 0 and timer == TIMEOUT-1 while incrementing, the next state is ABORT.
  - A termination arriving in the same cycle as the threshold wins: it is forwarded normally and there is no abort.
- ABORT (1 cycle):
  - s_cyc=s_stb=0.
  - Owner sees mN_err=1 for exactly this cycle. The non-owner sees 0.
  - Next state is DRAIN.
- DRAIN:
  - s_* = 0; owner terminations are 0.
  - Late s_ack/s_err/s_rty are ignored.
  - Waits for owner cyc=0, then goes to IDLE with last=owner.
- gnt is registered and one-hot in BUSY/ABORT/DRAIN. It is 00 in IDLE.
- Owner cyc dropping in the same cycle as a termination: the termination is forwarded and the state goes to IDLE.

Test Plan:
- m0 single read at adr 0x0000_0100: s_cyc rises 1 cycle after m0_cyc; slave acks with 0xDEADBEEF on its 1st STB cycle -> m0_ack=1, m0_dat_i=0xDEADBEEF, m1_ack=0, gnt=01, then IDLE after m0 drops cyc.
- Tie after reset: m0_cyc and m1_cyc both rise at cycle 5 -> m0 granted first. After m0 releases, there is 1 IDLE cycle, then gnt=10 for m1. A second tie after m1 finishes -> m0 is granted.
- Burst: m1 performs a 4-beat CTI 010/010/010/111 write while m0_cyc=1 throughout -> gnt stays 10 for all 4 acks. m0 is granted only after m1 drops cyc.
- Watchdog with TIMEOUT=8: m0 stb held, slave never acks -> s_cyc=0 and m0_err=1 exactly 8 cycles after the first stb cycle. Late s_ack in DRAIN is not forwarded. Return to IDLE after m0_cyc=0.
- Boundary with TIMEOUT=8: s_ack arrives on the 8th waiting cycle -> normal ack, no m0_err. With TIMEOUT=0, a 1000-cycle stall -> no abort.
- rst asserted for 1 cycle mid-burst on m1 -> next cycle s_cyc=0 and gnt=00. A subsequent tie grants m0.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B4 arbiter. Ownership is granted per CYC tenure with
// round-robin tie-break; a watchdog converts a stalled slave transfer into ERR.

module wb_arb_term (
  input  logic sel,
  input  logic abt,
  input  logic s_ack,
  input  logic s_err,
  input  logic s_rty,
  output logic ack,
  output logic err,
  output logic rty
);
  assign ack = sel & s_ack;
  assign err = (sel & s_err) | abt;
  assign rty = sel & s_rty;
endmodule

module wb_arbiter_2m #(
  parameter  int TIMEOUT = 255,
  localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_o,
  input  logic [2:0]  m0_cti,
  output logic [31:0] m0_dat_i,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rty,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_o,
  input  logic [2:0]  m1_cti,
  output logic [31:0] m1_dat_i,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rty,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  output logic [2:0]  s_cti,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_rty,
  output logic [1:0]  gnt
);
  typedef enum logic [1:0] {IDLE, BUSY, ABORT, DRAIN} state_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } wb_req_t;

  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last, last_nxt;
  logic [1:0]    gnt_nxt;
  logic [TW-1:0] timer, timer_nxt;
  wb_req_t [1:0] req;
  wb_req_t       cur;
  logic          busy, term;
  logic [1:0]    t_ack, t_err, t_rty;

  assign req[0] = {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_o, m0_cti};
  assign req[1] = {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_o, m1_cti};
  assign cur    = req[owner];
  assign busy   = (state == BUSY);
  assign term   = s_ack | s_err | s_rty;

  assign s_cyc   = busy & cur.cyc;
  assign s_stb   = busy & cur.stb;
  assign s_we    = busy & cur.we;
  assign s_adr   = busy ? cur.adr : '0;
  assign s_dat_o = busy ? cur.dat : '0;
  assign s_cti   = busy ? cur.cti : '0;

  // Read data is broadcast; ack/err/rty are the only qualifiers a master sees.
  assign m0_dat_i = s_dat_i;
  assign m1_dat_i = s_dat_i;

  for (genvar i = 0; i < 2; i++) begin : g_port
    wb_arb_term u_term (
      .sel   (busy & (owner == 1'(i))),
      .abt   ((state == ABORT) & (owner == 1'(i))),
      .s_ack (s_ack),
      .s_err (s_err),
      .s_rty (s_rty),
      .ack   (t_ack[i]),
      .err   (t_err[i]),
      .rty   (t_rty[i])
    );
  end

  assign m0_ack = t_ack[0];
  assign m0_err = t_err[0];
  assign m0_rty = t_rty[0];
  assign m1_ack = t_ack[1];
  assign m1_err = t_err[1];
  assign m1_rty = t_rty[1];

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    gnt_nxt   = gnt;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (m0_cyc | m1_cyc) begin
          owner_nxt = (m0_cyc & m1_cyc) ? ~last : m1_cyc;
          gnt_nxt   = {owner_nxt, ~owner_nxt};
          timer_nxt = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!cur.cyc) begin
          state_nxt = IDLE;
          last_nxt  = owner;
          gnt_nxt   = '0;
          timer_nxt = '0;
        end else if (cur.stb && !term) begin
          timer_nxt = timer + TW'(1);
          // A termination on the threshold cycle takes the else branch and wins.
          if (TIMEOUT != 0 && timer == TMAX) begin
            state_nxt = ABORT;
            timer_nxt = '0;
          end
        end else begin
          timer_nxt = '0;
        end
      end
      ABORT: state_nxt = DRAIN;
      DRAIN: begin
        if (!cur.cyc) begin
          state_nxt = IDLE;
          last_nxt  = owner;
          gnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      gnt   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      gnt   <= gnt_nxt;
      timer <= timer_nxt;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Drives two arbiters (watchdog 8 and watchdog disabled) from shared stimulus and
// compares every cycle against a tenure-level reference model.

module tb_wb_arbiter_2m;
  localparam int ND = 2;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        s_cyc;
    logic        s_stb;
    logic        s_we;
    logic [2:0]  s_cti;
    logic [31:0] s_adr;
    logic [31:0] s_dat;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [1:0]  rty;
    logic [31:0] d0;
    logic [31:0] d1;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [2:0]  m_cti [2];
  logic [31:0] s_dat_i = '0;
  logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
  obs_t        obs [ND];

  int n_chk = 0;
  int n_err = 0;

  // Reference state per DUT: current owner (-1 = none), last owner, consecutive
  // unanswered strobes, and whether the tenure is aborting or draining.
  int own    [ND] = '{-1, -1};
  int lst    [ND] = '{1, 1};
  int waited [ND] = '{0, 0};
  bit abt    [ND] = '{0, 0};
  bit drn    [ND] = '{0, 0};

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    logic [1:0]  o_gnt;
    logic        o_scyc, o_sstb, o_swe;
    logic [31:0] o_sadr, o_sdat, o_d0, o_d1;
    logic [2:0]  o_scti;
    logic        o_m0_ack, o_m0_err, o_m0_rty, o_m1_ack, o_m1_err, o_m1_rty;

    wb_arbiter_2m #(.TIMEOUT(d == 0 ? 8 : 0)) u_dut (
      .clk(clk), .rst(rst),
      .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
      .m0_dat_o(m_dat[0]), .m0_cti(m_cti[0]), .m0_dat_i(o_d0),
      .m0_ack(o_m0_ack), .m0_err(o_m0_err), .m0_rty(o_m0_rty),
      .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
      .m1_dat_o(m_dat[1]), .m1_cti(m_cti[1]), .m1_dat_i(o_d1),
      .m1_ack(o_m1_ack), .m1_err(o_m1_err), .m1_rty(o_m1_rty),
      .s_cyc(o_scyc), .s_stb(o_sstb), .s_we(o_swe), .s_adr(o_sadr),
      .s_dat_o(o_sdat), .s_cti(o_scti), .s_dat_i(s_dat_i),
      .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .gnt(o_gnt)
    );

    assign obs[d] = {o_gnt, o_scyc, o_sstb, o_swe, o_scti, o_sadr, o_sdat,
                     {o_m1_ack, o_m0_ack}, {o_m1_err, o_m0_err}, {o_m1_rty, o_m0_rty},
                     o_d0, o_d1};
  end

  function automatic int tmo(int d);
    return (d == 0) ? 8 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t mdl_out(int d);
    obs_t e;
    int   o;
    bit   live;
    e    = '0;
    o    = own[d];
    e.d0 = s_dat_i;
    e.d1 = s_dat_i;
    if (o < 0) return e;
    live  = !abt[d] && !drn[d];
    e.gnt = 2'(1 << o);
    if (live) begin
      e.s_cyc = m_cyc[o];
      e.s_stb = m_stb[o];
      e.s_we  = m_we[o];
      e.s_cti = m_cti[o];
      e.s_adr = m_adr[o];
      e.s_dat = m_dat[o];
    end
    e.ack[o] = live & s_ack;
    e.err[o] = (live & s_err) | abt[d];
    e.rty[o] = live & s_rty;
    return e;
  endfunction

  function automatic void mdl_step(int d);
    int o;
    o = own[d];
    if (rst) begin
      own[d] = -1; lst[d] = 1; waited[d] = 0; abt[d] = 0; drn[d] = 0;
    end else if (o < 0) begin
      if (m_cyc[0] && m_cyc[1]) own[d] = 1 - lst[d];
      else if (m_cyc[0])        own[d] = 0;
      else if (m_cyc[1])        own[d] = 1;
      waited[d] = 0;
    end else if (abt[d]) begin
      abt[d] = 0;
      drn[d] = 1;
    end else if (!m_cyc[o]) begin
      lst[d] = o; own[d] = -1; drn[d] = 0; waited[d] = 0;
    end else if (!drn[d]) begin
      if (m_stb[o] && !(s_ack || s_err || s_rty)) begin
        waited[d]++;
        if (tmo(d) != 0 && waited[d] == tmo(d)) begin
          abt[d]    = 1;
          waited[d] = 0;
        end
      end else begin
        waited[d] = 0;
      end
    end
  endfunction

  task automatic smp();
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      obs_t e;
      e = mdl_out(d);
      chk($sformatf("d%0d gnt", d),  64'(obs[d].gnt), 64'(e.gnt));
      chk($sformatf("d%0d sctl", d), 64'({obs[d].s_cyc, obs[d].s_stb, obs[d].s_we, obs[d].s_cti}),
                                     64'({e.s_cyc, e.s_stb, e.s_we, e.s_cti}));
      chk($sformatf("d%0d sadr", d), 64'(obs[d].s_adr), 64'(e.s_adr));
      chk($sformatf("d%0d sdat", d), 64'(obs[d].s_dat), 64'(e.s_dat));
      chk($sformatf("d%0d term", d), 64'({obs[d].ack, obs[d].err, obs[d].rty}),
                                     64'({e.ack, e.err, e.rty}));
      chk($sformatf("d%0d dati", d), {obs[d].d0, obs[d].d1}, {e.d0, e.d1});
    end
  endtask

  task automatic adv();
    @(posedge clk);
    for (int d = 0; d < ND; d++) mdl_step(d);
    #1;
  endtask

  task automatic tick();
    smp();
    adv();
  endtask

  task automatic mset(input int i, input bit cyc, input bit stb, input bit we,
                      input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m_cyc[i] = cyc; m_stb[i] = stb; m_we[i] = we;
    m_adr[i] = adr; m_dat[i] = dat; m_cti[i] = cti;
  endtask

  task automatic sset(input bit ack, input bit err, input bit rty, input logic [31:0] dat);
    s_ack = ack; s_err = err; s_rty = rty; s_dat_i = dat;
  endtask

  initial begin
    int n, e1, lo, rate;
    mset(0, 0, 0, 0, 0, 0, 0);
    mset(1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    adv(); adv();
    rst = 1'b0;
    smp();
    chk("rst gnt", 64'(obs[0].gnt), 64'd0);
    chk("rst scyc", 64'(obs[0].s_cyc), 64'd0);
    adv();

    // m0 single read
    mset(0, 1, 1, 0, 32'h100, 0, 3'b000);
    smp();
    chk("rd arb scyc", 64'(obs[0].s_cyc), 64'd0);
    adv();
    sset(1, 0, 0, 32'hDEADBEEF);
    smp();
    chk("rd scyc", 64'(obs[0].s_cyc), 64'd1);
    chk("rd adr", 64'(obs[0].s_adr), 64'h100);
    chk("rd m0 ack", 64'(obs[0].ack[0]), 64'd1);
    chk("rd m0 dat", 64'(obs[0].d0), 64'hDEADBEEF);
    chk("rd m1 ack", 64'(obs[0].ack[1]), 64'd0);
    chk("rd gnt", 64'(obs[0].gnt), 64'd1);
    adv();
    sset(0, 0, 0, 0);
    mset(0, 0, 0, 0, 0, 0, 0);
    tick();
    smp();
    chk("rd idle gnt", 64'(obs[0].gnt), 64'd0);
    adv();

    // tie after reset, then alternation
    rst = 1'b1; adv(); rst = 1'b0;
    repeat (4) tick();
    mset(0, 1, 1, 0, 32'h200, 0, 0);
    mset(1, 1, 1, 1, 32'h300, 32'h55, 0);
    tick();
    sset(1, 0, 0, 32'h11);
    smp();
    chk("tie1 gnt", 64'(obs[0].gnt), 64'd1);
    adv();
    sset(0, 0, 0, 0);
    mset(0, 0, 0, 0, 0, 0, 0);
    tick();
    smp();
    chk("tie dead gnt", 64'(obs[0].gnt), 64'd0);
    adv();
    sset(1, 0, 0, 0);
    smp();
    chk("tie m1 gnt", 64'(obs[0].gnt), 64'd2);
    chk("tie m1 adr", 64'(obs[0].s_adr), 64'h300);
    adv();
    sset(0, 0, 0, 0);
    mset(1, 0, 0, 0, 0, 0, 0);
    tick();
    mset(0, 1, 1, 0, 32'h204, 0, 0);
    mset(1, 1, 1, 0, 32'h304, 0, 0);
    tick();
    sset(1, 0, 0, 32'h22);
    smp();
    chk("tie2 gnt", 64'(obs[0].gnt), 64'd1);
    adv();
    sset(0, 0, 0, 0);
    mset(0, 0, 0, 0, 0, 0, 0);
    tick();

    // m1 4-beat burst while m0 keeps requesting
    mset(1, 1, 1, 1, 32'h400, 32'hA0, 3'b010);
    tick();
    mset(0, 1, 1, 0, 32'h500, 0, 0);
    for (int b = 0; b < 4; b++) begin
      mset(1, 1, 1, 1, 32'h400 + 32'(4 * b), 32'hA0 + 32'(b), (b == 3) ? 3'b111 : 3'b010);
      sset(1, 0, 0, 0);
      smp();
      chk($sformatf("burst%0d gnt", b), 64'(obs[0].gnt), 64'd2);
      chk($sformatf("burst%0d m1 ack", b), 64'(obs[0].ack[1]), 64'd1);
      adv();
    end
    sset(0, 0, 0, 0);
    mset(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    smp();
    chk("burst then m0 gnt", 64'(obs[0].gnt), 64'd1);
    adv();

    // watchdog: m0 stalls from the cycle just checked (first strobe cycle)
    n = 1;
    while (n < 20) begin
      smp();
      if (obs[0].err[0]) break;
      n++;
      adv();
    end
    chk("wdog latency", 64'(n), 64'd8);
    chk("wdog scyc", 64'(obs[0].s_cyc), 64'd0);
    chk("wdog off err", 64'(obs[1].err[0]), 64'd0);
    adv();
    sset(1, 0, 0, 32'h77);
    smp();
    chk("drain late ack", 64'(obs[0].ack[0]), 64'd0);
    adv();
    sset(0, 0, 0, 0);
    mset(0, 0, 0, 0, 0, 0, 0);
    tick();
    smp();
    chk("wdog idle gnt", 64'(obs[0].gnt), 64'd0);
    adv();

    // termination on the 8th waiting cycle beats the watchdog
    mset(0, 1, 1, 0, 32'h600, 0, 0);
    tick();
    repeat (7) tick();
    sset(1, 0, 0, 32'h88);
    smp();
    chk("bnd ack", 64'(obs[0].ack[0]), 64'd1);
    chk("bnd err", 64'(obs[0].err[0]), 64'd0);
    adv();
    sset(0, 0, 0, 0);
    smp();
    chk("bnd next err", 64'(obs[0].err[0]), 64'd0);
    chk("bnd next gnt", 64'(obs[0].gnt), 64'd1);
    adv();
    mset(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // watchdog disabled: long stall never aborts
    mset(0, 1, 1, 0, 32'h700, 0, 0);
    tick();
    e1 = 0; lo = 0;
    repeat (1000) begin
      smp();
      if (obs[1].err[0]) e1++;
      if (!obs[1].s_cyc) lo++;
      adv();
    end
    chk("t0 stall err", 64'(e1), 64'd0);
    chk("t0 stall scyc", 64'(lo), 64'd0);
    mset(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // reset in the middle of an m1 burst
    mset(1, 1, 1, 1, 32'h800, 32'hB0, 3'b010);
    tick();
    sset(1, 0, 0, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sset(0, 0, 0, 0);
    mset(0, 1, 1, 0, 32'h900, 0, 0);
    smp();
    chk("rst mid scyc", 64'(obs[0].s_cyc), 64'd0);
    chk("rst mid gnt", 64'(obs[0].gnt), 64'd0);
    adv();
    smp();
    chk("rst tie gnt", 64'(obs[0].gnt), 64'd1);
    adv();
    mset(0, 0, 0, 0, 0, 0, 0);
    mset(1, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // randomized traffic with slave moods (silent / slow / fast)
    rate = 35;
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) rate = 35 * int'($urandom_range(0, 2));
      for (int i = 0; i < 2; i++) begin
        if (!m_cyc[i]) m_cyc[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 9) == 0) m_cyc[i] = 1'b0;
        m_stb[i] = m_cyc[i] && ($urandom_range(0, 3) != 0);
        m_we[i]  = 1'($urandom);
        m_adr[i] = $urandom;
        m_dat[i] = $urandom;
        case ($urandom_range(0, 2))
          0:       m_cti[i] = 3'b000;
          1:       m_cti[i] = 3'b010;
          default: m_cti[i] = 3'b111;
        endcase
      end
      sset(int'($urandom_range(0, 99)) < rate, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 3, $urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
